// File: rtl/enc_pkg.sv
// enc_pkg: shared definitions for the sequential request encoder.
//   - state_e   : encoder FSM states (IDLE, SERVE)
//   - CODE_W    : default code width
//   - N_REQ     : request line count derived from CODE_W
//   - IDLE_CODE : code value presented whenever valid is low
package enc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned N_REQ  = 2 ** CODE_W;

  localparam logic [CODE_W-1:0] IDLE_CODE = {CODE_W{1'b1}};

endpackage : enc_pkg

// File: rtl/prio_find.sv
// prio_find: combinational lowest-set-bit finder.
// Bit 0 has the highest priority.
// Ports:
//   vec_i : input  [N-1:0]      candidate bit vector
//   idx_o : output [CODE_W-1:0] index of the lowest set bit (0 when none set)
//   any_o : output              high when at least one bit of vec_i is set
module prio_find #(
  parameter int unsigned CODE_W = 3,
  parameter int unsigned N      = 2 ** CODE_W
) (
  input  logic [N-1:0]      vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = {CODE_W{1'b0}};
    any_o = |vec_i;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? i[CODE_W-1:0] : idx_o;
    end
  end

endmodule : prio_find

// File: rtl/req_encoder_seq.sv
// req_encoder_seq: sequential 8-to-3 request encoder.
// Captures an active-low request vector and emits one code per pending
// request, lowest index first, over a valid/ready handshake.
// All outputs come straight from flops.
//
// Ports:
//   clk   : input              system clock, rising edge
//   rst   : input              asynchronous active-high reset
//   en_b  : input              active-low enable; high aborts / blocks capture
//   req_b : input  [N_REQ-1:0] active-low request lines
//   code  : output [CODE_W-1:0] index of the presented request
//   valid : output             code is valid
//   ready : input              consumer accepts code when valid && ready
//   busy  : output             snapshot still holds unserved requests
//   done  : output             one-cycle pulse when the last code is accepted
//
// Build option: define REQ_MERGE_EN to OR live requests into the pending set
// while serving; otherwise the captured snapshot is served unchanged.
module req_encoder_seq
  import enc_pkg::*;
#(
  parameter int unsigned       CODE_W    = enc_pkg::CODE_W,
  parameter int unsigned       N_REQ     = 2 ** CODE_W,
  parameter logic [CODE_W-1:0] IDLE_CODE = {CODE_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_b,
  input  logic [N_REQ-1:0]  req_b,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  localparam logic [N_REQ-1:0] BIT0 = N_REQ'(1);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept_s;
  logic [N_REQ-1:0]    next_vec_s;
  logic [CODE_W-1:0]   find_idx_s;
  logic                find_any_s;

  // Candidate vector: raw requests when idle, remaining (and optionally merged) set when serving.
  always_comb begin
    accept_s   = valid_q & ready;
    next_vec_s = {N_REQ{1'b0}};
    if (state_q == IDLE) begin
      next_vec_s = ~req_b;
    end else begin
      next_vec_s = pending_q & ~(accept_s ? (BIT0 << code_q) : {N_REQ{1'b0}});
`ifdef REQ_MERGE_EN
      // Clear first, then merge, so a bit accepted and re-asserted stays pending.
      next_vec_s = next_vec_s | (en_b ? {N_REQ{1'b0}} : ~req_b);
`else
      next_vec_s = next_vec_s;
`endif
    end
  end

  prio_find #(
    .CODE_W (CODE_W),
    .N      (N_REQ)
  ) u_prio_find (
    .vec_i (next_vec_s),
    .idx_o (find_idx_s),
    .any_o (find_any_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    code_d    = code_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en_b && find_any_s) begin
          state_d   = SERVE;
          pending_d = next_vec_s;
          code_d    = find_idx_s;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          pending_d = {N_REQ{1'b0}};
          code_d    = IDLE_CODE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
        end
      end
      SERVE: begin
        if (en_b) begin
          // Abort drops everything, including an accept in this cycle; no done.
          state_d   = IDLE;
          pending_d = {N_REQ{1'b0}};
          code_d    = IDLE_CODE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
        end else if (!find_any_s) begin
          state_d   = IDLE;
          pending_d = {N_REQ{1'b0}};
          code_d    = IDLE_CODE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          pending_d = next_vec_s;
          // A presented code stays latched until it is accepted.
          code_d    = accept_s ? find_idx_s : code_q;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = {N_REQ{1'b0}};
        code_d    = IDLE_CODE;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= {N_REQ{1'b0}};
      code_q    <= IDLE_CODE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : req_encoder_seq

// File: tb/tb_req_encoder_seq.sv
// tb_req_encoder_seq: directed plus randomized bench for req_encoder_seq,
// checked against a transaction-level reference model of the encoder.
module tb_req_encoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_b;
  logic [7:0] req_b;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  req_encoder_seq dut (
    .clk   (clk),
    .rst   (rst),
    .en_b  (en_b),
    .req_b (req_b),
    .code  (code),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of outstanding request indices plus what is on the bus.
  bit       m_serving = 1'b0;
  bit [7:0] m_set     = 8'h00;
  int       m_code    = 7;
  bit       m_valid   = 1'b0;
  bit       m_done    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 7;
  endfunction

  task automatic model_reset();
    m_serving = 1'b0;
    m_set     = 8'h00;
    m_code    = 7;
    m_valid   = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic model_edge();
    bit [7:0] reqs;
    bit       took;
    reqs   = ~req_b;
    m_done = 1'b0;
    if (!m_serving) begin
      if (!en_b && reqs != 8'h00) begin
        m_set     = reqs;
        m_serving = 1'b1;
        m_valid   = 1'b1;
        m_code    = lowest(m_set);
      end
    end else if (en_b) begin
      model_reset();
    end else begin
      took = m_valid && ready;
      if (took) m_set[m_code] = 1'b0;
`ifdef REQ_MERGE_EN
      m_set = m_set | reqs;
`endif
      if (m_set == 8'h00) begin
        model_reset();
        m_done = 1'b1;
      end else if (took) begin
        m_code = lowest(m_set);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".code"},  {29'd0, code}, m_code);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
    chk({tag, ".busy"},  {31'd0, busy},  {31'd0, m_serving});
    chk({tag, ".done"},  {31'd0, done},  {31'd0, m_done});
  endtask

  task automatic step(input logic e, input logic [7:0] r, input logic rd, input string tag);
    en_b  = e;
    req_b = r;
    ready = rd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic go_idle();
    step(1'b1, 8'hFF, 1'b0, "idle");
    step(1'b1, 8'hFF, 1'b0, "idle");
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".code"},  {29'd0, code}, 32'd7);
    chk({tag, ".valid"}, {31'd0, valid}, 32'd0);
    chk({tag, ".busy"},  {31'd0, busy},  32'd0);
    chk({tag, ".done"},  {31'd0, done},  32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_codes[4];

  initial begin
    rst   = 1'b1;
    en_b  = 1'b1;
    req_b = 8'hFF;
    ready = 1'b0;
    #1;
    compare_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single request at index 2.
    step(1'b0, 8'hFB, 1'b1, "single_cap");
    chk("single_code", {29'd0, code}, 32'd2);
    step(1'b0, 8'hFF, 1'b1, "single_acc");
    chk("single_done", {31'd0, done}, 32'd1);
    step(1'b0, 8'hFF, 1'b1, "single_idle");
    chk("single_valid_low", {31'd0, valid}, 32'd0);
    go_idle();

    // Multi-request drain with ready held high.
    exp_codes[0] = 0; exp_codes[1] = 3; exp_codes[2] = 5; exp_codes[3] = 7;
    step(1'b0, 8'h56, 1'b1, "drain_cap");
    for (int k = 0; k < 4; k++) begin
      chk("drain_code", {29'd0, code}, exp_codes[k]);
      step(1'b0, 8'hFF, 1'b1, "drain");
    end
    chk("drain_done", {31'd0, done}, 32'd1);
    go_idle();

    // Backpressure: code 0 held for three stalled cycles, then full drain.
    step(1'b0, 8'h56, 1'b0, "bp_cap");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'hFF, 1'b0, "bp_hold");
      chk("bp_hold_code", {29'd0, code}, 32'd0);
      chk("bp_hold_valid", {31'd0, valid}, 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      chk("bp_code", {29'd0, code}, exp_codes[k]);
      step(1'b0, 8'hFF, 1'b1, "bp_drain");
    end
    chk("bp_done", {31'd0, done}, 32'd1);
    go_idle();

    // Abort after two codes of a full vector.
    step(1'b0, 8'h00, 1'b1, "abort_cap");
    step(1'b0, 8'hFF, 1'b1, "abort_c0");
    step(1'b0, 8'hFF, 1'b1, "abort_c1");
    chk("abort_code_before", {29'd0, code}, 32'd2);
    step(1'b1, 8'hFF, 1'b1, "abort");
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    go_idle();

    // Late request while the presented code is stalled.
    step(1'b0, 8'hEF, 1'b0, "merge_cap");
    step(1'b0, 8'hFD, 1'b0, "merge_hold");
    chk("merge_held_code", {29'd0, code}, 32'd4);
    step(1'b0, 8'hFF, 1'b1, "merge_acc");
`ifdef REQ_MERGE_EN
    chk("merge_next_code", {29'd0, code}, 32'd1);
    step(1'b0, 8'hFF, 1'b1, "merge_acc2");
`endif
    chk("merge_done", {31'd0, done}, 32'd1);
    go_idle();

    // Reset in the middle of a burst.
    step(1'b0, 8'h00, 1'b0, "rst_cap");
    pulse_reset("rst_mid");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic       e;
      logic [7:0] r;
      logic       rd;
      e  = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rd = ($urandom_range(0, 9) < 7);
      step(e, r, rd, "rand");
      if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_req_encoder_seq
